// File: rtl/neuai_seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with shadow/active digit registers and frame-aligned commit.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 is always shown).
module neuai_seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       commit,
    output logic       commit_pending,
    output logic [7:0] led_7seg,
    output logic [3:0] dig_n,
    output logic       frame_done
);

    localparam int CNT_W = 21;

    typedef enum logic [1:0] {ST_OFF, ST_DRIVE, ST_BLANK} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0][3:0]  shadow_val_q, shadow_val_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic [3:0][3:0]  active_val_q, active_val_d;
    logic [3:0]       active_dp_q, active_dp_d;
    logic             pending_q, pending_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       dig_n_q, dig_n_d;
    logic             apply_copy;
    logic             digit_on;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    // Scan sequencer: OFF -> BLANK(idx 3) -> DRIVE(0) -> BLANK -> DRIVE(1) ...
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q + CNT_W'(1);
        frame_done = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (en) begin
                    state_d = ST_BLANK;
                    idx_d   = 2'd3;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
                    state_d    = ST_DRIVE;
                    idx_d      = idx_q + 2'd1;
                    cnt_d      = '0;
                    frame_done = (idx_q == 2'd3);
                end
            end
        endcase
        // Disable wins over any scheduled transition; an aborted frame is not a boundary.
        if (!en) begin
            state_d    = ST_OFF;
            cnt_d      = '0;
            frame_done = 1'b0;
        end
    end

    assign wr_ready       = !pending_q;
    assign commit_pending = pending_q;
    assign apply_copy     = pending_q && (frame_done || state_q == ST_OFF);

    // Writes are blocked while pending, so the copy never races a shadow update.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;
        if (wr_valid && wr_ready) begin
            shadow_val_d[wr_addr] = wr_data;
            shadow_dp_d[wr_addr]  = wr_dp;
        end
        if (apply_copy) begin
            active_val_d = shadow_val_q;
            active_dp_d  = shadow_dp_q;
            pending_d    = 1'b0;
        end else if (commit && wr_ready) begin
            pending_d = 1'b1;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [3:0] dig_zero;
    logic [3:0] lead_zero;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dig_zero[i] = (active_val_q[i] == 4'h0) && !active_dp_q[i];
        end
        lead_zero[3] = dig_zero[3];
        lead_zero[2] = dig_zero[2] && lead_zero[3];
        lead_zero[1] = dig_zero[1] && lead_zero[2];
        lead_zero[0] = 1'b0;
        digit_on     = !lead_zero[idx_q];
    end
`else
    assign digit_on = 1'b1;
`endif

    // Outputs are computed from the current state and registered, so they lag state entry by one cycle.
    always_comb begin
        seg_d   = 8'h00;
        dig_n_d = 4'hF;
        if (state_q == ST_DRIVE && digit_on) begin
            dig_n_d = ~(4'b0001 << idx_q);
            seg_d   = {active_dp_q[idx_q], seg_decode(active_val_q[idx_q])};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q      <= ST_OFF;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            // NOTE: the digit registers are tiny and must read as zero after reset, so they are reset too.
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 8'h00;
            dig_n_q      <= 4'hF;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dig_n_q      <= dig_n_d;
        end
    end

    assign led_7seg = seg_q;
    assign dig_n    = dig_n_q;

endmodule

// File: tb/tb_neuai_seg_scan_ctrl.sv
// Directed bench for neuai_seg_scan_ctrl with SCAN_DIV=4, BLANK_CYC=2 (24-cycle frame).
// Honours SEG_LEADING_ZERO_BLANK_EN when choosing the expected leading-zero display.
module tb_neuai_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       commit;
    logic       commit_pending;
    logic [7:0] led_7seg;
    logic [3:0] dig_n;
    logic       frame_done;

    int n_vec = 0;
    int n_bad = 0;
    int n_wait;

    neuai_seg_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .commit(commit),
        .commit_pending(commit_pending), .led_7seg(led_7seg),
        .dig_n(dig_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input int limit, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!frame_done && n < limit);
        check("fd_wait", 32'(frame_done), 32'd1);
    endtask

    // Starts in a boundary cycle (minus already-consumed ticks); ends in the next boundary cycle.
    task automatic check_frame(input string tag, input logic [3:0][7:0] segs,
                               input logic [3:0][3:0] digs, input int first);
        for (int i = 0; i < 4; i++) begin
            tick(i == 0 ? first : 2);
            check($sformatf("%s_d%0d_first", tag, i), 32'({dig_n, led_7seg}), 32'({digs[i], segs[i]}));
            tick(3);
            check($sformatf("%s_d%0d_last", tag, i), 32'({dig_n, led_7seg}), 32'({digs[i], segs[i]}));
            tick(1);
            check($sformatf("%s_d%0d_blank", tag, i), 32'({dig_n, led_7seg}), 32'h0F00);
        end
        check($sformatf("%s_fd", tag), 32'(frame_done), 32'd1);
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] d, input logic dp, input logic c);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_dp = dp; commit = c;
        tick(1);
        wr_valid = 1'b0; commit = 1'b0;
    endtask

    localparam logic [3:0][3:0] DIGS_ALL = {4'h7, 4'hB, 4'hD, 4'hE};

    initial begin
        rst = 1'b0; en = 1'b1; wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'h0;
        wr_dp = 1'b0; commit = 1'b1;
        tick(3);
        wr_valid = 1'b0; commit = 1'b0; en = 1'b0;
        rst = 1'b1;
        tick(1);
        check("rst_dig_n", 32'(dig_n), 32'h0F);
        check("rst_led", 32'(led_7seg), 32'h00);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_pending", 32'(commit_pending), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd1);

        // Power-up frame: two BLANK cycles, boundary, then all zeros scanned.
        en = 1'b1;
        wait_fd(10, n_wait);
        check("en_fd_latency", 32'(n_wait), 32'd2);
        check_frame("zero", {8'h3F, 8'h3F, 8'h3F, 8'h3F}, DIGS_ALL, 2);

        // Load 1,2,3,4 with commit mid-frame; later write and commit are refused.
        write(2'd0, 4'h1, 1'b0, 1'b0);
        write(2'd1, 4'h2, 1'b0, 1'b0);
        write(2'd2, 4'h3, 1'b0, 1'b0);
        write(2'd3, 4'h4, 1'b0, 1'b1);
        check("commit_pending_set", 32'(commit_pending), 32'd1);
        check("ready_low", 32'(wr_ready), 32'd0);
        write(2'd0, 4'h9, 1'b0, 1'b1);
        check("pending_hold", 32'(commit_pending), 32'd1);
        tick(3);
        check("old_display_d1", 32'({dig_n, led_7seg}), 32'h0D3F);
        wait_fd(30, n_wait);
        check("pending_at_boundary", 32'(commit_pending), 32'd1);
        check_frame("load", {8'h66, 8'h4F, 8'h5B, 8'h06}, DIGS_ALL, 2);
        check("pending_clear", 32'(commit_pending), 32'd0);
        check("ready_high", 32'(wr_ready), 32'd1);

        // Write A+dp and commit in the boundary cycle itself: waits a whole frame.
        write(2'd2, 4'hA, 1'b1, 1'b1);
        check("bnd_commit_pending", 32'(commit_pending), 32'd1);
        check_frame("wait", {8'h66, 8'h4F, 8'h5B, 8'h06}, DIGS_ALL, 1);
        check("bnd_commit_still", 32'(commit_pending), 32'd1);
        check_frame("dp", {8'h66, 8'hF7, 8'h5B, 8'h06}, DIGS_ALL, 2);

        // Drop enable during digit 0's slot, then re-enable.
        tick(2);
        en = 1'b0;
        tick(2);
        check("off_blank", 32'({dig_n, led_7seg}), 32'h0F00);
        en = 1'b1;
        wait_fd(10, n_wait);
        check("reen_fd_latency", 32'(n_wait), 32'd2);
        check_frame("reen", {8'h66, 8'hF7, 8'h5B, 8'h06}, DIGS_ALL, 2);

        // Commit while OFF is applied on the following edge.
        en = 1'b0;
        tick(2);
        write(2'd1, 4'h0, 1'b0, 1'b1);
        check("off_pending_set", 32'(commit_pending), 32'd1);
        tick(1);
        check("off_pending_done", 32'(commit_pending), 32'd0);
        en = 1'b1;
        wait_fd(10, n_wait);
        check_frame("offcommit", {8'h66, 8'hF7, 8'h3F, 8'h06}, DIGS_ALL, 2);

        // Leading zeros: active = 5,0,0,0 (digit 0 = 5).
        en = 1'b0;
        tick(2);
        write(2'd0, 4'h5, 1'b0, 1'b0);
        write(2'd1, 4'h0, 1'b0, 1'b0);
        write(2'd2, 4'h0, 1'b0, 1'b0);
        write(2'd3, 4'h0, 1'b0, 1'b1);
        tick(1);
        check("lz_applied", 32'(commit_pending), 32'd0);
        en = 1'b1;
        wait_fd(10, n_wait);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_frame("lz", {8'h00, 8'h00, 8'h00, 8'h6D}, {4'hF, 4'hF, 4'hF, 4'hE}, 2);
`else
        check_frame("lz", {8'h3F, 8'h3F, 8'h3F, 8'h6D}, DIGS_ALL, 2);
`endif

        // Reset overrides an active display and a simultaneous commit.
        tick(2);
        rst = 1'b0; wr_valid = 1'b1; commit = 1'b1;
        tick(1);
        check("rst2_outputs", 32'({dig_n, led_7seg}), 32'h0F00);
        check("rst2_pending", 32'(commit_pending), 32'd0);
        check("rst2_fd", 32'(frame_done), 32'd0);
        rst = 1'b1; wr_valid = 1'b0; commit = 1'b0; en = 1'b0;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/neuai_seg_scan_ctrl.md
NEUAI_SEG_SCAN_CTRL -- requirements
Module: neuai_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving clk cycles each digit is driven per scan slot (legal range 2..2^20).
REQ-002 The block SHALL have parameter BLANK_CYC, default 16, giving all-digits-off clk cycles between slots (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: display enable.
REQ-006 The block SHALL have port wr_valid, input, 1 bit: shadow-register write request.
REQ-007 The block SHALL have port wr_ready, output, 1 bit: write/commit accepted when high.
REQ-008 The block SHALL have port wr_addr, input, 2 bits: digit index 0..3.
REQ-009 The block SHALL have port wr_data, input, 4 bits: hex value 0..F.
REQ-010 The block SHALL have port wr_dp, input, 1 bit: decimal point for that digit.
REQ-011 The block SHALL have port commit, input, 1 bit: one-cycle request to copy shadow to active at the next frame boundary.
REQ-012 The block SHALL have port commit_pending, output, 1 bit: high from commit acceptance until the copy is done.
REQ-013 The block SHALL have port led_7seg, output, 8 bits: registered segments pgfe_dcba, active-high.
REQ-014 The block SHALL have port dig_n, output, 4 bits: registered digit enables, active-low, bit i = digit i.
REQ-015 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-016 The state machine SHALL have states OFF, DRIVE and BLANK, with a 2-bit digit index idx.
REQ-017 In OFF: dig_n=4'hF, led_7seg=0; when en=1 the next state SHALL be BLANK with idx=3.
REQ-018 In DRIVE: dig_n drives bit idx low only, led_7seg = decode(active[idx]) with bit7 = active dp[idx]; after exactly SCAN_DIV cycles the next state SHALL be BLANK.
REQ-019 In BLANK: dig_n=4'hF, led_7seg=0; after exactly BLANK_CYC cycles the next state SHALL be DRIVE with idx = idx+1 mod 4 (3 wraps to 0).
REQ-020 The frame boundary SHALL be the last BLANK cycle with idx=3; frame_done pulses high in that cycle only.
REQ-021 The decode SHALL map 0..F to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex, bits 6..0).
REQ-022 led_7seg and dig_n SHALL be registered, reflecting the state one cycle after state entry, with no cycle in which two digits are enabled.
REQ-023 wr_ready SHALL equal !commit_pending; a write with wr_valid&wr_ready updates shadow[wr_addr] and shadow dp on the next edge.
REQ-024 commit&wr_ready SHALL set commit_pending; commit while commit_pending=1 SHALL be ignored.
REQ-025 A write and a commit in the same accepted cycle SHALL both take effect, and the copy SHALL include that write.
REQ-026 On a frame boundary with commit_pending=1 (set before that cycle), shadow SHALL be copied to active and commit_pending cleared on the same edge; a commit accepted in the boundary cycle itself SHALL wait for the next boundary.
REQ-027 If en falls in any state, the next state SHALL be OFF with outputs blank from the following cycle.
REQ-028 A commit pending while in OFF SHALL be applied one cycle after it is set.
REQ-029 Divider counters SHALL restart from 0 on every state entry.

Reset
REQ-030 With rst=0 at a clock edge, the block SHALL enter OFF with idx=0, counters=0, shadow/active/dp=0, commit_pending=0, wr_ready=1 after release, led_7seg=8'h00, dig_n=4'hF and frame_done=0; reset SHALL override all other inputs.

Configuration
REQ-031 When SEG_LEADING_ZERO_BLANK_EN is defined, a digit i in 1..3 whose active value and dp are 0 and for which all higher digits are also 0 with dp 0 SHALL be driven with dig_n=4'hF and led_7seg=0 for its DRIVE slot, and digit 0 SHALL always be shown.
REQ-032 When SEG_LEADING_ZERO_BLANK_EN is undefined, all four digits SHALL always be shown.

Verification (SCAN_DIV=4, BLANK_CYC=2)
REQ-033 Reset then en=1 -> 2 BLANK cycles, frame_done pulse, then dig_n=1110 for 4 cycles, led_7seg=3F.
REQ-034 Write digits 1,2,3,4 (addr0..3), commit mid-frame -> display unchanged until next frame_done, then digits show 06,5B,4F,66; commit_pending high until that edge.
REQ-035 Write during commit_pending -> wr_ready=0, shadow unchanged; second commit ignored.
REQ-036 Write value A with dp=1 and commit in the same cycle -> after boundary led_7seg=F7 on that digit.
REQ-037 Drop en mid DRIVE -> next cycle dig_n=1111, led_7seg=00; re-enable restarts at idx 0 after BLANK.
REQ-038 With macro defined, active=0,0,0,5 -> only digit 0 enabled (6D); digits 1..3 dig_n stay 1111 during their slots.
